// File: rtl/inpkt_header_parser_pkg.sv
// Shared constants, state encoding and status-bit map
// for the host packet header parser.
package inpkt_header_parser_pkg;

   localparam int HDR_LEN  = 10;
   localparam int CSUM_LEN = 4;

   localparam logic [3:0] OFF_VERSION = 4'd0;
   localparam logic [3:0] OFF_TYPE    = 4'd1;
   localparam logic [3:0] OFF_LEN0    = 4'd4;
   localparam logic [3:0] OFF_LEN1    = 4'd5;
   localparam logic [3:0] OFF_LEN2    = 4'd6;
   localparam logic [3:0] OFF_ID0     = 4'd8;
   localparam logic [3:0] OFF_ID1     = 4'd9;

   // Bit positions of the sticky flags within pkt_comm_status
   localparam int ERR_BITS         = 4;
   localparam int ERR_BIT_VERSION  = 0;
   localparam int ERR_BIT_TYPE     = 1;
   localparam int ERR_BIT_LEN      = 2;
   localparam int ERR_BIT_CHECKSUM = 3;

   typedef enum logic [2:0] {
      ST_HDR,
      ST_HDR_CSUM,
      ST_DATA,
      ST_DATA_CSUM,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/inpkt_header_parser_checksum.sv
// 32-bit byte-lane checksum accumulator; output is the
// inverted running sum, ready to compare with the wire value.
module pkt_checksum32 (
   input  logic        CLK,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [1:0]  idx,
   input  logic [7:0]  data,
   output logic [31:0] csum
);

   logic [31:0] sum;

   always_ff @(posedge CLK) begin
      if (rst || clr)
         sum <= '0;
      else if (en)
         sum <= sum + ({24'h0, data} << {idx, 3'b000});
   end

   assign csum = ~sum;

endmodule

// File: rtl/inpkt_header_parser.sv
// Host packet parser: validates header and checksums,
// streams payload bytes and raises sticky error flags.
module inpkt_header_parser
   import inpkt_header_parser_pkg::*;
#(
   parameter logic [7:0] VERSION      = 8'd2,
   parameter logic [7:0] PKT_TYPE_MAX = 8'd3,
   parameter int         PKT_MAX_LEN  = 16384
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic [7:0]  din,
   input  logic        empty,
   output logic        rd_en,
   output logic [7:0]  dout,
   output logic        wr_en,
   input  logic        full,
   output logic [7:0]  pkt_type,
   output logic [15:0] pkt_id,
   output logic [23:0] pkt_len,
   output logic        pkt_new,
   output logic        pkt_end,
   output logic        err_pkt_version,
   output logic        err_pkt_type,
   output logic        err_pkt_len,
   output logic        err_pkt_checksum
);

   state_t              state;
   logic [23:0]         cnt;
   logic [7:0]          sh_ver;
   logic [7:0]          sh_type;
   logic [23:0]         sh_len;
   logic [15:0]         sh_id;
   logic [23:0]         csum_rx;
   logic [ERR_BITS-1:0] err_q;

   logic        ck_clr;
   logic        ck_en;
   logic [1:0]  ck_idx;
   logic [31:0] ck_sum;

   logic csum_last;
   logic csum_ok;
   logic bad_ver;
   logic bad_type;
   logic bad_len;

   assign csum_last = cnt == 24'(CSUM_LEN - 1);
   assign csum_ok   = {din, csum_rx} == ck_sum;
   assign bad_ver   = sh_ver != VERSION;
   assign bad_type  = sh_type == 8'd0
                   || sh_type > PKT_TYPE_MAX;
   assign bad_len   = sh_len == 24'd0
                   || sh_len > 24'(PKT_MAX_LEN);

   always_comb begin
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      pkt_end = 1'b0;
      ck_en   = 1'b0;
      ck_clr  = 1'b0;
      ck_idx  = cnt[1:0];
      if (!rst) begin
         case (state)
            ST_HDR: begin
               rd_en = !empty;
               ck_en = !empty;
            end
            ST_HDR_CSUM, ST_DATA_CSUM: begin
               rd_en  = !empty;
               ck_clr = !empty && csum_last;
            end
            ST_DATA: begin
               // cnt holds the bytes still to come
               wr_en   = !empty && !full;
               rd_en   = wr_en;
               ck_en   = wr_en;
               ck_idx  = pkt_len[1:0] - cnt[1:0];
               pkt_end = wr_en && cnt == 24'd1;
            end
            default: ;
         endcase
      end
      dout = wr_en ? din : 8'h00;
   end

   pkt_checksum32 u_csum (
      .CLK  (CLK),
      .rst  (rst),
      .clr  (ck_clr),
      .en   (ck_en),
      .idx  (ck_idx),
      .data (din),
      .csum (ck_sum)
   );

   always_ff @(posedge CLK) begin
      if (rst) begin
         state    <= ST_HDR;
         cnt      <= '0;
         sh_ver   <= '0;
         sh_type  <= '0;
         sh_len   <= '0;
         sh_id    <= '0;
         csum_rx  <= '0;
         err_q    <= '0;
         pkt_type <= '0;
         pkt_id   <= '0;
         pkt_len  <= '0;
         pkt_new  <= 1'b0;
      end else begin
         pkt_new <= 1'b0;
         case (state)
            ST_HDR: if (rd_en) begin
               case (cnt[3:0])
                  OFF_VERSION: sh_ver        <= din;
                  OFF_TYPE:    sh_type       <= din;
                  OFF_LEN0:    sh_len[7:0]   <= din;
                  OFF_LEN1:    sh_len[15:8]  <= din;
                  OFF_LEN2:    sh_len[23:16] <= din;
                  OFF_ID0:     sh_id[7:0]    <= din;
                  OFF_ID1:     sh_id[15:8]   <= din;
                  default: ;
               endcase
               if (cnt == 24'(HDR_LEN - 1)) begin
                  cnt   <= '0;
                  state <= ST_HDR_CSUM;
               end else begin
                  cnt <= cnt + 24'd1;
               end
            end
            ST_HDR_CSUM: if (rd_en) begin
               csum_rx <= {din, csum_rx[23:8]};
               if (!csum_last) begin
                  cnt <= cnt + 24'd1;
               end else if (!csum_ok) begin
                  cnt                     <= '0;
                  err_q[ERR_BIT_CHECKSUM] <= 1'b1;
                  state                   <= ST_ERROR;
               end else if (bad_ver || bad_type || bad_len) begin
                  cnt                    <= '0;
                  err_q[ERR_BIT_VERSION] <= bad_ver;
                  err_q[ERR_BIT_TYPE]    <= bad_type;
                  err_q[ERR_BIT_LEN]     <= bad_len;
                  state                  <= ST_ERROR;
               end else begin
                  pkt_type <= sh_type;
                  pkt_id   <= sh_id;
                  pkt_len  <= sh_len;
                  pkt_new  <= 1'b1;
                  cnt      <= sh_len;
                  state    <= ST_DATA;
               end
            end
            ST_DATA: if (wr_en) begin
               if (cnt == 24'd1) begin
                  cnt   <= '0;
                  state <= ST_DATA_CSUM;
               end else begin
                  cnt <= cnt - 24'd1;
               end
            end
            ST_DATA_CSUM: if (rd_en) begin
               csum_rx <= {din, csum_rx[23:8]};
               if (!csum_last) begin
                  cnt <= cnt + 24'd1;
               end else begin
                  cnt <= '0;
                  if (csum_ok) begin
                     state <= ST_HDR;
                  end else begin
                     err_q[ERR_BIT_CHECKSUM] <= 1'b1;
                     state                   <= ST_ERROR;
                  end
               end
            end
            ST_ERROR: ;
            default: state <= ST_ERROR;
         endcase
      end
   end

   assign err_pkt_version  = err_q[ERR_BIT_VERSION];
   assign err_pkt_type     = err_q[ERR_BIT_TYPE];
   assign err_pkt_len      = err_q[ERR_BIT_LEN];
   assign err_pkt_checksum = err_q[ERR_BIT_CHECKSUM];

endmodule

// File: tb/tb_inpkt_header_parser.sv
// Randomised bench for the packet parser: FIFO source,
// stalling sink and a packet-level reference model.
module tb_inpkt_header_parser;

   logic        CLK = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  din = 8'h00;
   logic        empty = 1'b1;
   logic        full = 1'b0;
   logic        rd_en;
   logic [7:0]  dout;
   logic        wr_en;
   logic [7:0]  pkt_type;
   logic [15:0] pkt_id;
   logic [23:0] pkt_len;
   logic        pkt_new;
   logic        pkt_end;
   logic        err_pkt_version;
   logic        err_pkt_type;
   logic        err_pkt_len;
   logic        err_pkt_checksum;

   always #5 CLK = ~CLK;

   inpkt_header_parser dut (
      .CLK              (CLK),
      .rst              (rst),
      .din              (din),
      .empty            (empty),
      .rd_en            (rd_en),
      .dout             (dout),
      .wr_en            (wr_en),
      .full             (full),
      .pkt_type         (pkt_type),
      .pkt_id           (pkt_id),
      .pkt_len          (pkt_len),
      .pkt_new          (pkt_new),
      .pkt_end          (pkt_end),
      .err_pkt_version  (err_pkt_version),
      .err_pkt_type     (err_pkt_type),
      .err_pkt_len      (err_pkt_len),
      .err_pkt_checksum (err_pkt_checksum)
   );

   typedef struct packed {
      logic [7:0]  t;
      logic [15:0] id;
      logic [23:0] len;
      logic [31:0] reads;
   } ev_t;

   int checks = 0;
   int errors = 0;
   int reads = 0;
   int pushed = 0;
   int viol = 0;

   logic [7:0] src[$];
   logic [7:0] got[$];
   logic [7:0] exp_data[$];
   int         ends[$];
   int         exp_ends[$];
   ev_t        news[$];
   ev_t        exp_news[$];

   logic [3:0] errs;
   assign errs = {err_pkt_checksum, err_pkt_len,
                  err_pkt_type, err_pkt_version};

   logic [7:0] lit [22] = '{
      8'h02, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00,
      8'h00, 8'h34, 8'h12, 8'hC5, 8'hEC, 8'hFF, 8'hFF,
      8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55, 8'h44, 8'h33,
      8'h22};

   function automatic logic [31:0] csum(input logic [7:0] b[$]);
      logic [31:0] s = 32'd0;
      foreach (b[i]) s += 32'(b[i]) << (8 * (i % 4));
      return ~s;
   endfunction

   function automatic int diff_data();
      int d = (got.size() != exp_data.size()) ? 1 : 0;
      for (int i = 0; i < got.size() && i < exp_data.size(); i++)
         if (got[i] !== exp_data[i]) d++;
      return d;
   endfunction

   function automatic int diff_ends();
      int d = (ends.size() != exp_ends.size()) ? 1 : 0;
      for (int i = 0; i < ends.size() && i < exp_ends.size(); i++)
         if (ends[i] != exp_ends[i]) d++;
      return d;
   endfunction

   function automatic int diff_news();
      int d = (news.size() != exp_news.size()) ? 1 : 0;
      for (int i = 0; i < news.size() && i < exp_news.size(); i++)
         if (news[i] !== exp_news[i]) d++;
      return d;
   endfunction

   task automatic push(input logic [7:0] b);
      src.push_back(b);
      pushed++;
   endtask

   // Build one packet from its fields; 'accept' says whether
   // the header is legal, so the model expects pkt_new + payload.
   task automatic add_pkt(input logic [7:0] ver,
                          input logic [7:0] typ,
                          input logic [23:0] len,
                          input logic [15:0] id,
                          input int plen,
                          input bit accept,
                          input bit bad_pcs);
      logic [7:0] h[$];
      logic [7:0] p[$];
      logic [31:0] c;
      ev_t e;
      h.push_back(ver);
      h.push_back(typ);
      h.push_back(8'($urandom));
      h.push_back(8'($urandom));
      h.push_back(len[7:0]);
      h.push_back(len[15:8]);
      h.push_back(len[23:16]);
      h.push_back(8'($urandom));
      h.push_back(id[7:0]);
      h.push_back(id[15:8]);
      c = csum(h);
      foreach (h[i]) push(h[i]);
      for (int i = 0; i < 4; i++) push(c[8*i +: 8]);
      if (accept) begin
         e = '{typ, id, len, 32'(pushed)};
         exp_news.push_back(e);
      end
      for (int i = 0; i < plen; i++) p.push_back(8'($urandom));
      c = csum(p) ^ {31'd0, bad_pcs};
      foreach (p[i]) begin
         push(p[i]);
         if (accept) exp_data.push_back(p[i]);
      end
      if (accept && plen > 0) exp_ends.push_back(exp_data.size() - 1);
      for (int i = 0; i < 4; i++) push(c[8*i +: 8]);
   endtask

   task automatic lit_pkt(input logic [7:0] b10, input bit accept);
      ev_t e;
      if (accept) begin
         e = '{8'h01, 16'h1234, 24'd4, 32'(pushed + 14)};
         exp_news.push_back(e);
         exp_data.push_back(8'hAA);
         exp_data.push_back(8'hBB);
         exp_data.push_back(8'hCC);
         exp_data.push_back(8'hDD);
         exp_ends.push_back(exp_data.size() - 1);
      end
      for (int i = 0; i < 22; i++) push(i == 10 ? b10 : lit[i]);
   endtask

   // fmode: 0 never full, 1 toggling, 2 random
   task automatic step(input int gap, input int fmode);
      ev_t e;
      @(negedge CLK);
      case (fmode)
         1: full = ~full;
         2: full = 1'($urandom_range(1));
         default: full = 1'b0;
      endcase
      empty = (src.size() == 0) || ($urandom_range(99) < gap);
      din = empty ? 8'($urandom) : src[0];
      #1;
      if ((rd_en && empty) || (wr_en && full) || (pkt_end && !wr_en))
         viol++;
      if (pkt_new) begin
         e = '{pkt_type, pkt_id, pkt_len, 32'(reads)};
         news.push_back(e);
      end
      if (wr_en) begin
         got.push_back(dout);
         if (pkt_end) ends.push_back(got.size() - 1);
      end
      if (rd_en) begin
         void'(src.pop_front());
         reads++;
      end
   endtask

   task automatic drain(input int gap, input int fmode, input int max);
      int n = 0;
      while (src.size() != 0 && n < max) begin
         step(gap, fmode);
         n++;
      end
      checks++;
      if (src.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d bytes unread after %0d cycles, required 0",
                  src.size(), n);
      end
      repeat (4) step(0, 0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      rst = 1'b1;
      empty = 1'b1;
      full = 1'b0;
      repeat (2) @(negedge CLK);
      src.delete(); got.delete(); exp_data.delete();
      ends.delete(); exp_ends.delete();
      news.delete(); exp_news.delete();
      reads = 0;
      pushed = 0;
      viol = 0;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      rst = 1'b1;
      empty = 1'b0;
      full = 1'b0;
      din = 8'h5A;
      @(negedge CLK);
      #1;
      checks++;
      if (rd_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_rd_en: got %b, required 0", rd_en);
      end
      checks++;
      if ({wr_en, pkt_new, pkt_end} !== 3'b000) begin
         errors++;
         $display("FAIL reset_strobes: wr/new/end %b, required 000",
                  {wr_en, pkt_new, pkt_end});
      end
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("FAIL reset_dout: got %h, required 00", dout);
      end
      checks++;
      if ({pkt_type, pkt_id, pkt_len} !== 48'd0) begin
         errors++;
         $display("FAIL reset_fields: got %h %h %h, required 0",
                  pkt_type, pkt_id, pkt_len);
      end
      checks++;
      if (errs !== 4'b0000) begin
         errors++;
         $display("FAIL reset_errs: got %b, required 0000", errs);
      end
      do_reset();
   endtask

   task automatic test_valid_packet();
      do_reset();
      lit_pkt(8'hC5, 1'b1);
      drain(0, 0, 200);
      checks++;
      if (diff_news() != 0) begin
         errors++;
         $display("FAIL valid_hdr: %0d events, required type 01 id 1234 len 4 once",
                  news.size());
      end
      checks++;
      if (diff_data() != 0) begin
         errors++;
         $display("FAIL valid_data: %0d bytes (first %h), required AA BB CC DD",
                  got.size(), got.size() > 0 ? got[0] : 8'h00);
      end
      checks++;
      if (diff_ends() != 0) begin
         errors++;
         $display("FAIL valid_end: %0d pkt_end pulses, required one on DD",
                  ends.size());
      end
      checks++;
      if (errs !== 4'b0000 || viol != 0) begin
         errors++;
         $display("FAIL valid_flags: errs %b viol %0d, required 0000 and 0",
                  errs, viol);
      end
   endtask

   task automatic test_stall();
      do_reset();
      lit_pkt(8'hC5, 1'b1);
      drain(35, 1, 400);
      checks++;
      if (diff_data() != 0 || diff_ends() != 0) begin
         errors++;
         $display("FAIL stall_data: %0d bytes %0d ends, required 4 bytes 1 end",
                  got.size(), ends.size());
      end
      checks++;
      if (diff_news() != 0) begin
         errors++;
         $display("FAIL stall_hdr: %0d events, required 1 matching", news.size());
      end
      checks++;
      if (viol != 0 || errs !== 4'b0000) begin
         errors++;
         $display("FAIL stall_handshake: viol %0d errs %b, required 0 and 0000",
                  viol, errs);
      end
   endtask

   task automatic test_random_packets();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         int l = $urandom_range(40, 1);
         add_pkt(8'h02, 8'($urandom_range(3, 1)), 24'(l),
                 16'($urandom), l, 1'b1, 1'b0);
      end
      drain(25, 2, 4000);
      checks++;
      if (diff_data() != 0) begin
         errors++;
         $display("FAIL random_data: %0d wrong of %0d got, required %0d",
                  diff_data(), got.size(), exp_data.size());
      end
      checks++;
      if (diff_ends() != 0) begin
         errors++;
         $display("FAIL random_end: %0d ends, required %0d",
                  ends.size(), exp_ends.size());
      end
      checks++;
      if (diff_news() != 0) begin
         errors++;
         $display("FAIL random_hdr: %0d wrong, %0d events, required %0d",
                  diff_news(), news.size(), exp_news.size());
      end
      checks++;
      if (viol != 0 || errs !== 4'b0000) begin
         errors++;
         $display("FAIL random_flags: viol %0d errs %b, required 0 and 0000",
                  viol, errs);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      add_pkt(8'h02, 8'h02, 24'd4, 16'hBEEF, 4, 1'b1, 1'b0);
      add_pkt(8'h02, 8'h03, 24'd4, 16'hCAFE, 4, 1'b1, 1'b0);
      drain(0, 0, 200);
      checks++;
      if (news.size() != 2 || news[1].reads != 32'd36) begin
         errors++;
         $display("FAIL b2b_gap: %0d events, 2nd at read %0d, required 2 and 36",
                  news.size(), news.size() > 1 ? news[1].reads : 0);
      end
      checks++;
      if (diff_news() != 0 || diff_data() != 0) begin
         errors++;
         $display("FAIL b2b_content: %0d bad events %0d bad bytes, required 0",
                  diff_news(), diff_data());
      end
   endtask

   task automatic test_hdr_checksum();
      do_reset();
      lit_pkt(8'hC6, 1'b0);
      for (int i = 0; i < 8; i++) push(8'($urandom));
      repeat (40) step(0, 0);
      checks++;
      if (errs !== 4'b1000) begin
         errors++;
         $display("FAIL hcs_errs: got %b, required 1000", errs);
      end
      checks++;
      if (news.size() != 0 || got.size() != 0) begin
         errors++;
         $display("FAIL hcs_output: %0d pkt_new %0d bytes, required 0 and 0",
                  news.size(), got.size());
      end
      checks++;
      if (reads != 14) begin
         errors++;
         $display("FAIL hcs_halt: %0d reads, required 14", reads);
      end
   endtask

   task automatic test_field_errors();
      for (int k = 0; k < 8; k++) begin
         logic [7:0]  v;
         logic [7:0]  t;
         logic [23:0] l;
         logic [3:0]  ef;
         bit          ok;
         case (k)
            0: {v, t, l} = {8'h03, 8'h01, 24'd4};
            1: {v, t, l} = {8'h02, 8'h01, 24'h004001};
            2: {v, t, l} = {8'h02, 8'h00, 24'd4};
            default: begin
               v = $urandom_range(1) ? 8'h02 : 8'($urandom);
               t = $urandom_range(2) ? 8'($urandom_range(3)) : 8'($urandom);
               case ($urandom_range(2))
                  0: l = 24'd0;
                  1: l = 24'($urandom_range(8, 1));
                  default: l = 24'($urandom_range(200000, 16385));
               endcase
            end
         endcase
         ef = {1'b0, l == 0 || l > 16384, t == 0 || t > 3, v != 8'h02};
         ok = ef == 4'b0000;
         do_reset();
         add_pkt(v, t, l, 16'($urandom), ok ? int'(l) : 0, ok, 1'b0);
         if (!ok) for (int i = 0; i < 8; i++) push(8'($urandom));
         repeat (60) step(0, 0);
         checks++;
         if (errs !== ef) begin
            errors++;
            $display("FAIL field_errs[%0d]: v %h t %h l %h got %b, required %b",
                     k, v, t, l, errs, ef);
         end
         checks++;
         if (diff_news() != 0 || diff_data() != 0) begin
            errors++;
            $display("FAIL field_out[%0d]: %0d events %0d bytes, required %0d and %0d",
                     k, news.size(), got.size(), exp_news.size(), exp_data.size());
         end
         checks++;
         if (reads != (ok ? 18 + int'(l) : 14)) begin
            errors++;
            $display("FAIL field_reads[%0d]: %0d reads, required %0d",
                     k, reads, ok ? 18 + int'(l) : 14);
         end
      end
   endtask

   task automatic test_payload_checksum();
      do_reset();
      add_pkt(8'h02, 8'h02, 24'd6, 16'h0F0F, 6, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) push(8'($urandom));
      repeat (60) step(0, 0);
      checks++;
      if (errs !== 4'b1000) begin
         errors++;
         $display("FAIL pcs_errs: got %b, required 1000", errs);
      end
      checks++;
      if (diff_data() != 0 || diff_news() != 0) begin
         errors++;
         $display("FAIL pcs_output: %0d bytes %0d events, required 6 and 1",
                  got.size(), news.size());
      end
      checks++;
      if (reads != 24) begin
         errors++;
         $display("FAIL pcs_halt: %0d reads, required 24", reads);
      end
   endtask

   task automatic test_mid_reset();
      int n = 0;
      do_reset();
      add_pkt(8'h02, 8'h03, 24'd20, 16'h7777, 20, 1'b1, 1'b0);
      while (got.size() < 3 && n < 200) begin
         step(0, 0);
         n++;
      end
      checks++;
      if (got.size() < 3) begin
         errors++;
         $display("FAIL midrst_start: %0d bytes before reset, required 3",
                  got.size());
      end
      do_reset();
      lit_pkt(8'hC5, 1'b1);
      drain(10, 2, 400);
      checks++;
      if (diff_news() != 0 || diff_data() != 0 || diff_ends() != 0) begin
         errors++;
         $display("FAIL midrst_parse: %0d events %0d bytes, required 1 and 4",
                  news.size(), got.size());
      end
      checks++;
      if (errs !== 4'b0000 || viol != 0) begin
         errors++;
         $display("FAIL midrst_flags: errs %b viol %0d, required 0000 and 0",
                  errs, viol);
      end
   endtask

   initial begin
      test_reset();
      test_valid_packet();
      test_stall();
      test_random_packets();
      test_back_to_back();
      test_hdr_checksum();
      test_field_errors();
      test_payload_checksum();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
